fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single framebuffer write port between N_REQ drawing clients.
//  Grants bursts of up to BURST_LEN writes per owner.
//  Sits between the draw engines and the framebuffer RAM; takes vblnk from the VGA timing block.
//  Optionally restricts writes to vertical blanking for tear-free update.
// PARAMETERS
//  N_REQ     4   number of requesters (2..8)
//  ADDR_W    19  framebuffer address width
//  DATA_W    12  pixel width (RGB444)
//  BURST_LEN 16  max accepted beats per grant (>=1)
// PORTS
//  clk        in   1             pixel clock
//  rst        in   1             synchronous, active-high reset
//  vblnk      in   1             vertical blank from VGA timing; used only with FB_ARB_VBLANK_GATE_EN
//  req        in   N_REQ         per-requester write valid; held with addr/data until acked
//  req_addr   in   N_REQ*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
//  req_data   in   N_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
//  ack        out  N_REQ         one-hot, combinational: beat accepted at this clock edge
//  mem_we     out  1             registered framebuffer write enable
//  mem_addr   out  ADDR_W        registered write address
//  mem_wdata  out  DATA_W        registered write data
//  owner      out  $clog2(N_REQ) index of the current or last grant holder
//  busy       out  1             high while in BURST
// BEHAVIOUR
//  gate = vblnk with FB_ARB_VBLANK_GATE_EN, else 1'b1.
//  Reset values:
//   - state = IDLE; mem_we, mem_addr, mem_wdata, ack, busy, owner = 0
//   - last-served ptr = N_REQ-1, so requester 0 wins first
//   - beat_cnt = 0
//  IDLE:
//   - ack = 0
//   - if gate && |req: pick first i with req[i] set, searching ptr+1, ptr+2 ... (mod N_REQ)
//   - owner <= i; beat_cnt <= 0; go to BURST
//   - otherwise stay in IDLE
//  BURST:
//   - ack[owner] = req[owner] && gate; all other ack bits are 0
//   - an accepted beat registers mem_we = 1, mem_addr and mem_wdata from the owner's slice
//     (latency 1 cycle: ack at edge N, RAM write visible at edge N+1)
//   - each beat does beat_cnt++
//   - exit to IDLE with ptr <= owner when the first of these holds:
//     a) req[owner] low
//     b) beat accepted with beat_cnt == BURST_LEN-1
//     c) gate low
//   - mem_we = 0 in any cycle without an accepted beat
//  Arbitration bubble: one idle cycle between bursts, no ack in IDLE.
//   Max throughput = BURST_LEN/(BURST_LEN+1).
//  Simultaneous events:
//   - gate falling in the cycle of the last beat: the beat is not accepted and the FSM exits
//   - a requester dropping req mid-burst forfeits the rest of its burst; ptr advances
//  Reset mid-burst:
//   - next cycle: state IDLE, mem_we = 0, ptr = N_REQ-1
//   - an in-flight registered write is discarded
//  owner width: max($clog2(N_REQ),1).
// CONFIGURATION
//  FB_ARB_VBLANK_GATE_EN defined:
//   - grants and acks only while vblnk = 1
//   - a burst in progress is cut when vblnk falls
//  Undefined:
//   - vblnk is ignored and writes are granted at any time (tearing allowed)
// TESTING
//  1. Reset; req = 4'b0001, 3 beats, gate high
//     -> ack[0] on cycles 2..4; mem_we on 3..5 with matching addr/data
//  2. req = 4'b1111 held continuously, BURST_LEN = 4
//     -> owners 0,1,2,3,0 in turn; 4 beats each; 1 idle cycle between grants
//  3. Owner 2 drops req after 2 beats while req[3] is high
//     -> burst ends; next grant goes to 3 after one bubble
//  4. GATE_EN: req[1] high, vblnk low
//     -> no ack
//     vblnk rises -> grant one cycle later
//     vblnk falls mid-burst -> ack drops the same cycle; mem_we = 0 the next cycle
//  5. GATE_EN off: vblnk held 0, req[0] high
//     -> writes proceed at BURST_LEN/(BURST_LEN+1) rate
//  6. rst asserted mid-burst of requester 2
//     -> mem_we = 0 and ack = 0 next cycle
//     with req = 4'b0101 after release -> requester 0 granted first

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter that shares the framebuffer write port among N_REQ draw clients, with bursts of up to BURST_LEN beats.
// Latency: ack at edge N, registered RAM write at edge N+1; one idle arbitration cycle between bursts. Define FB_ARB_VBLANK_GATE_EN to confine writes to vblnk.
// Backpressure: a requester holds req/addr/data until it sees ack; no ack in IDLE or while the gate is closed.
module fb_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 12,
    parameter int BURST_LEN = 16,
    localparam int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vblnk,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         ack,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [OW-1:0]            owner,
    output logic                     busy
);

    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state, state_nxt;
    logic [OW-1:0]     ptr;
    logic [OW-1:0]     pick_idx;
    logic [OW-1:0]     cand;
    logic              pick_vld;
    logic              gate;
    logic              accept;
    logic              burst_end;
    logic [CW-1:0]     beat_cnt;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_data;

`ifdef FB_ARB_VBLANK_GATE_EN
    assign gate = vblnk;
`else
    logic unused_vblnk;
    assign unused_vblnk = vblnk;
    assign gate = 1'b1;
`endif

    // Walk downwards so the candidate closest after ptr is written last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = OW'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        own_addr = '0;
        own_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == OW'(i)) begin
                own_addr = req_addr[i*ADDR_W +: ADDR_W];
                own_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ack       = '0;
        accept    = 1'b0;
        burst_end = 1'b0;
        case (state)
            IDLE: begin
                if (gate && pick_vld)
                    state_nxt = BURST;
            end
            BURST: begin
                accept     = req[owner] && gate;
                ack[owner] = accept;
                burst_end  = !req[owner] || !gate ||
                             (accept && beat_cnt == CW'(BURST_LEN - 1));
                if (burst_end)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= '0;
            ptr       <= OW'(N_REQ - 1);
            beat_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= accept;
            if (state == IDLE && state_nxt == BURST) begin
                owner    <= pick_idx;
                beat_cnt <= '0;
            end
            if (accept) begin
                mem_addr  <= own_addr;
                mem_wdata <= own_data;
                beat_cnt  <= beat_cnt + CW'(1);
            end
            if (state == BURST && burst_end)
                ptr <= owner;
        end
    end

    assign busy = (state == BURST);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_fb_write_arbiter;
    localparam int N  = 4;
    localparam int AW = 19;
    localparam int DW = 12;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            vblnk;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [1:0]      owner;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit            m_busy  = 0;
    logic [1:0]    m_owner = '0;
    logic [1:0]    m_ptr   = 2'(N-1);
    int            m_cnt   = 0;
    bit            m_we    = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;

    fb_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .req(req), .req_addr(req_addr),
        .req_data(req_data), .ack(ack), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic bit gate_now();
`ifdef FB_ARB_VBLANK_GATE_EN
        return vblnk;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [N-1:0] model_ack();
        logic [N-1:0] r;
        r = '0;
        if (m_busy && req[m_owner] && gate_now())
            r[m_owner] = 1'b1;
        return r;
    endfunction

    task automatic model_edge();
        bit g, acc;
        logic [1:0] c;
        g = gate_now();
        if (rst) begin
            m_busy = 0; m_owner = '0; m_ptr = 2'(N-1); m_cnt = 0;
            m_we = 0; m_addr = '0; m_data = '0;
            return;
        end
        if (!m_busy) begin
            m_we = 0;
            if (g && req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    c = 2'((int'(m_ptr) + k) % N);
                    if (req[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_busy = 1;
                m_cnt  = 0;
            end
        end else begin
            acc  = req[m_owner] && g;
            m_we = acc;
            if (acc) begin
                m_addr = req_addr[int'(m_owner)*AW +: AW];
                m_data = req_data[int'(m_owner)*DW +: DW];
            end
            if (!req[m_owner] || !g || (acc && m_cnt == BL-1)) begin
                m_busy = 0;
                m_ptr  = m_owner;
            end
            if (acc) m_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_pl(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0;
        tick(); tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", owner); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        req = 4'b1111;
        @(negedge clk);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp 0000", ack); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy got %b exp 0", busy); end
        req = '0; rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int beats;
        logic [N-1:0] a, e;
        beats = 0;
        do_reset();
        set_pl(0, 19'd100, 12'h0A0);
        req = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            a = ack;
            e = (c >= 2 && c <= 4) ? 4'b0001 : 4'b0000;
            checks++; if (a !== e) begin errors++; $display("FAIL single_ack c=%0d got %b exp %b", c, a, e); end
            tick();
            checks++; if (mem_we !== (c >= 2 && c <= 4)) begin errors++; $display("FAIL single_we c=%0d got %b", c, mem_we); end
            if (c >= 2 && c <= 4) begin
                checks++;
                if (mem_addr !== AW'(100 + c - 2) || mem_wdata !== DW'(12'h0A0 + c - 2)) begin
                    errors++; $display("FAIL single_wr c=%0d got %h/%h exp %h/%h", c, mem_addr, mem_wdata, AW'(100 + c - 2), DW'(12'h0A0 + c - 2));
                end
            end
            checks++; if (busy !== (c <= 4)) begin errors++; $display("FAIL single_busy c=%0d got %b", c, busy); end
            checks++; if (owner !== 2'd0) begin errors++; $display("FAIL single_owner c=%0d got %0d exp 0", c, owner); end
            if (a[0]) begin
                beats++;
                set_pl(0, AW'(100 + beats), DW'(12'h0A0 + beats));
                if (beats == 3) req = '0;
            end
        end
    endtask

    task automatic test_rr();
        int n[N];
        int q, o;
        logic [N-1:0] a, e;
        do_reset();
        for (int i = 0; i < N; i++) begin
            n[i] = 0;
            set_pl(i, AW'(i*4096), DW'(i*256));
        end
        req = 4'b1111;
        for (int p = 1; p <= 25; p++) begin
            q = (p - 1) % 5;
            o = ((p - 1) / 5) % N;
            e = (q == 0) ? 4'b0000 : 4'(1 << o);
            @(negedge clk);
            a = ack;
            checks++; if (a !== e) begin errors++; $display("FAIL rr_ack p=%0d got %b exp %b", p, a, e); end
            tick();
            checks++; if (mem_we !== (q != 0)) begin errors++; $display("FAIL rr_we p=%0d got %b", p, mem_we); end
            if (q != 0) begin
                checks++; if (mem_addr !== AW'(o*4096 + n[o])) begin errors++; $display("FAIL rr_addr p=%0d got %h exp %h", p, mem_addr, AW'(o*4096 + n[o])); end
            end
            checks++; if (owner !== 2'(o)) begin errors++; $display("FAIL rr_owner p=%0d got %0d exp %0d", p, owner, o); end
            checks++; if (busy !== (q != 4)) begin errors++; $display("FAIL rr_busy p=%0d got %b", p, busy); end
            for (int i = 0; i < N; i++) begin
                if (a[i]) begin
                    n[i]++;
                    set_pl(i, AW'(i*4096 + n[i]), DW'(i*256 + n[i]));
                end
            end
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_drop();
        logic [N-1:0] tbl [6];
        int beats;
        tbl = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000};
        beats = 0;
        do_reset();
        set_pl(2, 19'h2_0000, 12'h222);
        set_pl(3, 19'h3_0000, 12'h333);
        req = 4'b1100;
        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            checks++; if (ack !== tbl[p]) begin errors++; $display("FAIL drop_ack p=%0d got %b exp %b", p, ack, tbl[p]); end
            if (ack[2]) beats++;
            tick();
            if (p == 3) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_bubble got %b exp 0", busy); end
            end
            if (beats == 2) req[2] = 1'b0;
        end
        checks++; if (owner !== 2'd3) begin errors++; $display("FAIL drop_owner got %0d exp 3", owner); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 19'h3_0000) begin errors++; $display("FAIL drop_wr got %b/%h exp 1/30000", mem_we, mem_addr); end
        req = '0;
        tick(); tick();
    endtask

`ifdef FB_ARB_VBLANK_GATE_EN
    task automatic test_gate();
        vblnk = 1'b0;
        do_reset();
        set_pl(1, 19'h1_2345, 12'h111);
        req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL gate_closed_ack c=%0d got %b", c, ack); end
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_closed_busy c=%0d got %b", c, busy); end
        end
        vblnk = 1'b1;
        @(negedge clk);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL gate_open_ack got %b exp 0000", ack); end
        tick();
        checks++; if (busy !== 1'b1 || owner !== 2'd1) begin errors++; $display("FAIL gate_grant got %b/%0d exp 1/1", busy, owner); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL gate_beat_ack c=%0d got %b exp 0010", c, ack); end
            tick();
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL gate_beat_we c=%0d got %b exp 1", c, mem_we); end
        end
        vblnk = 1'b0;
        @(negedge clk);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL gate_cut_ack got %b exp 0000", ack); end
        tick();
        checks++; if (mem_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL gate_cut got we=%b busy=%b exp 0/0", mem_we, busy); end
        req = '0;
        vblnk = 1'b1;
        tick();
    endtask
`else
    task automatic test_nogate();
        int acks, wes;
        logic [N-1:0] e;
        acks = 0; wes = 0;
        vblnk = 1'b0;
        do_reset();
        set_pl(0, 19'h0_0042, 12'h042);
        req = 4'b0001;
        for (int p = 1; p <= 20; p++) begin
            e = ((p - 1) % 5 != 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            checks++; if (ack !== e) begin errors++; $display("FAIL nogate_ack p=%0d got %b exp %b", p, ack, e); end
            if (ack[0]) acks++;
            tick();
            if (mem_we) wes++;
        end
        checks++; if (acks != 16) begin errors++; $display("FAIL nogate_acks got %0d exp 16", acks); end
        checks++; if (wes != 16) begin errors++; $display("FAIL nogate_writes got %0d exp 16", wes); end
        req = '0;
        vblnk = 1'b1;
        tick();
    endtask
`endif

    task automatic test_rst_mid();
        do_reset();
        set_pl(2, 19'h2_0AAA, 12'hAAA);
        req = 4'b0100;
        @(negedge clk);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rstmid_idle_ack got %b exp 0000", ack); end
        tick();
        checks++; if (busy !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL rstmid_grant got %b/%0d exp 1/2", busy, owner); end
        @(negedge clk);
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL rstmid_beat_ack got %b exp 0100", ack); end
        tick();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_beat_we got %b exp 1", mem_we); end
        rst = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_after got we=%b busy=%b exp 0/0", mem_we, busy); end
        @(negedge clk);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rstmid_ack got %b exp 0000", ack); end
        rst = 1'b0;
        set_pl(0, 19'h0_0555, 12'h555);
        req = 4'b0101;
        tick();
        checks++; if (busy !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL rstmid_regrant got %b/%0d exp 1/0", busy, owner); end
        @(negedge clk);
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rstmid_first_ack got %b exp 0001", ack); end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_random();
        logic [N-1:0] a, e;
        do_reset();
        vblnk = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 19) == 0) vblnk = ~vblnk;
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_pl(i, AW'($urandom), DW'($urandom));
                end
            end
            @(negedge clk);
            a = ack;
            e = model_ack();
            checks++; if (a !== e) begin errors++; $display("FAIL rand_ack cyc=%0d got %b exp %b", cyc, a, e); end
            tick();
            checks++; if (mem_we !== m_we) begin errors++; $display("FAIL rand_we cyc=%0d got %b exp %b", cyc, mem_we, m_we); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got %b exp %b", cyc, busy, m_busy); end
            checks++; if (owner !== m_owner) begin errors++; $display("FAIL rand_owner cyc=%0d got %0d exp %0d", cyc, owner, m_owner); end
            checks++; if (mem_addr !== m_addr || mem_wdata !== m_data) begin errors++; $display("FAIL rand_wr cyc=%0d got %h/%h exp %h/%h", cyc, mem_addr, mem_wdata, m_addr, m_data); end
            for (int i = 0; i < N; i++) begin
                if (a[i]) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
                    else set_pl(i, AW'($urandom), DW'($urandom));
                end
            end
        end
        rst = 1'b0;
        req = '0;
        tick();
    endtask

    initial begin
        rst = 1'b1; vblnk = 1'b1; req = '0; req_addr = '0; req_data = '0;
        test_reset();
        test_single();
        test_rr();
        test_drop();
`ifdef FB_ARB_VBLANK_GATE_EN
        test_gate();
`else
        test_nogate();
`endif
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
